uart_rx_fifo: RTL

Receive-side byte FIFO that sits directly downstream of the UART Receiver. It captures each completed byte, where o_rx_data is qualified by the o_rx_done pulse, and buffers it for the host or consumer logic. It also returns back-pressure to the Receiver: o_full drives the Receiver's i_fifo_full. Single clock domain, registered read port, status flags and a sticky overrun indicator.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_fifo_mem.sv | 21 ++
 rtl/uart_rx_fifo.sv | 79 +++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the byte type used by receiver, transmitter and FIFOs
package uart_pkg;
  localparam int UART_SIZE_DATA = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;
  typedef logic [UART_SIZE_DATA-1:0] uart_byte_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: register array; i_wr_en/i_wr_addr/i_wr_data write port, i_rd_en/i_rd_addr -> registered o_rd_data
module uart_fifo_mem #(
  parameter int SIZE_DATA = 8,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic [$clog2(DEPTH)-1:0]   i_wr_addr,
  input  logic [SIZE_DATA-1:0]       i_wr_data,
  input  logic                       i_rd_en,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
  output logic [SIZE_DATA-1:0]       o_rd_data
);
  logic [SIZE_DATA-1:0] mem_q [DEPTH];
  logic [SIZE_DATA-1:0] rd_data_q, rd_data_d;
  always_comb rd_data_d = i_rd_en ? mem_q[i_rd_addr] : rd_data_q;
  always_ff @(posedge i_clk) if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
  always_ff @(posedge i_clk) rd_data_q <= !i_rst_n ? '0 : rd_data_d;
  assign o_rd_data = rd_data_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte FIFO; i_wr_* from receiver, i_rd_en -> o_rd_data/o_rd_valid, o_full/o_empty/o_almost_full/o_count, sticky o_overrun
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int SIZE_DATA = UART_SIZE_DATA,
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic [SIZE_DATA-1:0]       i_wr_data,
  input  logic                       i_rd_en,
  input  logic                       i_clr_overrun,
  output logic [SIZE_DATA-1:0]       o_rd_data,
  output logic                       o_rd_valid,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_almost_full,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overrun
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W = ADDR_W + 1;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic full_q, full_d, empty_q, empty_d, af_q, af_d;
  logic overrun_q, overrun_d, rd_valid_q, rd_valid_d;
  logic rd_acc, wr_acc;
  always_comb begin
    rd_acc = i_rd_en && !empty_q;
    wr_acc = i_wr_en && (!full_q || rd_acc);
    wr_ptr_d = wr_ptr_q + ADDR_W'(wr_acc);
    rd_ptr_d = rd_ptr_q + ADDR_W'(rd_acc);
    count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    full_d = count_d == CNT_W'(DEPTH);
    empty_d = count_d == '0;
    af_d = count_d >= CNT_W'(AF_LEVEL);
    overrun_d = (i_wr_en && !wr_acc) ? 1'b1 : i_clr_overrun ? 1'b0 : overrun_q;
    rd_valid_d = rd_acc;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      af_q <= 1'b0;
      overrun_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      full_q <= full_d;
      empty_q <= empty_d;
      af_q <= af_d;
      overrun_q <= overrun_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  uart_fifo_mem #(.SIZE_DATA(SIZE_DATA), .DEPTH(DEPTH)) u_mem (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_wr_en(wr_acc),
    .i_wr_addr(wr_ptr_q),
    .i_wr_data(i_wr_data),
    .i_rd_en(rd_acc),
    .i_rd_addr(rd_ptr_q),
    .o_rd_data(o_rd_data)
  );
  assign o_rd_valid = rd_valid_q;
  assign o_full = full_q;
  assign o_empty = empty_q;
  assign o_almost_full = af_q;
  assign o_count = count_q;
  assign o_overrun = overrun_q;
endmodule
